// File: rtl/aes_bridge_pkg.sv
// Shared types and geometry for the AES I/O bridge: FSM states and the
// 32-bit word / 128-bit block layout used by the bridge and its word registers.
package aes_bridge_pkg;

    localparam int WORD_W          = 32;
    localparam int WORDS_PER_BLOCK = 4;
    localparam int BLOCK_W         = 128;
    localparam int IDX_W           = 2;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [2:0] {
        LOAD_KEY,
        LOAD_MSG,
        WAIT_AES,
        UNLOAD,
        RESTART
    } bridge_state_t;

endpackage

// File: rtl/aes_word_reg.sv
// 128-bit block register with 32-bit indexed write/read (index 0 = MSW),
// whole-block load and synchronous clear.
module aes_word_reg
    import aes_bridge_pkg::*;
(
    input  logic                 clk,
    input  logic                 i_clear,
    input  logic                 i_wr_en,
    input  logic [IDX_W-1:0]     i_idx,
    input  logic [WORD_W-1:0]    i_wr_data,
    input  logic                 i_load,
    input  logic [BLOCK_W-1:0]   i_load_data,
    output logic [WORD_W-1:0]    o_rd_data,
    output logic [BLOCK_W-1:0]   o_block
);

    logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] r_data;
    logic [IDX_W-1:0]                       w_slot;

    // Word index 0 is the most significant slot, so the packed slot is reversed.
    assign w_slot = LAST_IDX - i_idx;

    always_ff @(posedge clk) begin
        if (i_clear) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_load_data;
        end else if (i_wr_en) begin
            r_data[w_slot] <= i_wr_data;
        end
    end

    assign o_rd_data = r_data[w_slot];
    assign o_block   = r_data;

endmodule

// File: rtl/aes_io_bridge.sv
// Streams a key and a ciphertext block into an AES controller and streams the
// plaintext back out. Optional watchdog enabled by `define AES_BRIDGE_TIMEOUT_EN.
module aes_io_bridge
    import aes_bridge_pkg::*;
#(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd1024
)
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    in_data,
    output logic [127:0]   key,
    output logic [127:0]   msg_en,
    output logic           io_ready,
    input  logic           aes_ready,
    input  logic [127:0]   msg_de,
    output logic           aes_reset_n,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_data,
    output logic           out_last,
    output logic           timeout_err
);

    bridge_state_t      r_state;
    bridge_state_t      w_next_state;
    logic [IDX_W-1:0]   r_idx;
    logic [IDX_W-1:0]   w_next_idx;
    logic               w_key_wr;
    logic               w_msg_wr;
    logic               w_res_load;
    logic               w_clear;
    logic               w_timeout;
    logic [WORD_W-1:0]  w_unused_key_word;
    logic [WORD_W-1:0]  w_unused_msg_word;
    logic [BLOCK_W-1:0] w_unused_res_block;

    assign w_clear = ~reset_n;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= LOAD_KEY;
            r_idx   <= '0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_next_idx;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_next_idx   = r_idx;
        w_key_wr     = 1'b0;
        w_msg_wr     = 1'b0;
        w_res_load   = 1'b0;
        case (r_state)
            LOAD_KEY: begin
                if (in_valid) begin
                    w_key_wr   = 1'b1;
                    w_next_idx = r_idx + 2'd1;
                    if (r_idx == LAST_IDX) w_next_state = LOAD_MSG;
                end
            end
            LOAD_MSG: begin
                if (in_valid) begin
                    w_msg_wr   = 1'b1;
                    w_next_idx = r_idx + 2'd1;
                    if (r_idx == LAST_IDX) w_next_state = WAIT_AES;
                end
            end
            WAIT_AES: begin
                // A completion on the same cycle as the watchdog expiry wins.
                if (aes_ready) begin
                    w_res_load   = 1'b1;
                    w_next_state = UNLOAD;
                    w_next_idx   = '0;
                end else if (w_timeout) begin
                    w_next_state = RESTART;
                    w_next_idx   = '0;
                end
            end
            UNLOAD: begin
                if (out_ready) begin
                    w_next_idx = r_idx + 2'd1;
                    if (r_idx == LAST_IDX) w_next_state = RESTART;
                end
            end
            RESTART: begin
                w_next_state = LOAD_KEY;
                w_next_idx   = '0;
            end
            default: begin
                w_next_state = LOAD_KEY;
                w_next_idx   = '0;
            end
        endcase
    end

`ifdef AES_BRIDGE_TIMEOUT_EN
    logic [15:0] r_wdog;
    logic        r_timeout_err;

    // Counter sits at zero outside WAIT_AES, so it starts fresh on every entry.
    always_ff @(posedge clk) begin
        if (!reset_n || r_state != WAIT_AES) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 16'd1;
        end
    end

    assign w_timeout = (r_state == WAIT_AES) && (r_wdog == TIMEOUT_CYCLES - 16'd1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout && !aes_ready) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    logic [15:0] w_unused_timeout;

    assign w_unused_timeout = TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
    assign timeout_err      = 1'b0;
`endif

    aes_word_reg u_key_reg (
        .clk         (clk),
        .i_clear     (w_clear),
        .i_wr_en     (w_key_wr),
        .i_idx       (r_idx),
        .i_wr_data   (in_data),
        .i_load      (1'b0),
        .i_load_data ('0),
        .o_rd_data   (w_unused_key_word),
        .o_block     (key)
    );

    aes_word_reg u_msg_reg (
        .clk         (clk),
        .i_clear     (w_clear),
        .i_wr_en     (w_msg_wr),
        .i_idx       (r_idx),
        .i_wr_data   (in_data),
        .i_load      (1'b0),
        .i_load_data ('0),
        .o_rd_data   (w_unused_msg_word),
        .o_block     (msg_en)
    );

    aes_word_reg u_res_reg (
        .clk         (clk),
        .i_clear     (w_clear),
        .i_wr_en     (1'b0),
        .i_idx       (r_idx),
        .i_wr_data   ('0),
        .i_load      (w_res_load),
        .i_load_data (msg_de),
        .o_rd_data   (out_data),
        .o_block     (w_unused_res_block)
    );

    assign in_ready    = (r_state == LOAD_KEY) || (r_state == LOAD_MSG);
    assign io_ready    = (r_state == WAIT_AES);
    assign out_valid   = (r_state == UNLOAD);
    assign out_last    = out_valid && (r_idx == LAST_IDX);
    assign aes_reset_n = reset_n && (r_state != RESTART);

endmodule

// File: tb/tb_aes_io_bridge.sv
// Directed bench for aes_io_bridge: load/decrypt/unload round trip, stalls,
// mid-load reset and, when AES_BRIDGE_TIMEOUT_EN is defined, the watchdog.
module tb_aes_io_bridge;

`ifdef AES_BRIDGE_TIMEOUT_EN
    localparam logic [15:0] TB_TIMEOUT = 16'd16;
    localparam int          AES_DELAY  = 10;
`else
    localparam logic [15:0] TB_TIMEOUT = 16'd1024;
    localparam int          AES_DELAY  = 20;
`endif

    logic         clk;
    logic         reset_n;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_data;
    logic [127:0] key;
    logic [127:0] msg_en;
    logic         io_ready;
    logic         aes_ready;
    logic [127:0] msg_de;
    logic         aes_reset_n;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_data;
    logic         out_last;
    logic         timeout_err;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] loadWords [8] = '{32'h00010203, 32'h04050607, 32'h08090a0b, 32'h0c0d0e0f,
                                   32'h69c4e0d8, 32'h6a7b0430, 32'hd8cdb780, 32'h70b4c55a};
    logic [31:0] plainWords [4] = '{32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff};

    aes_io_bridge #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .key         (key),
        .msg_en      (msg_en),
        .io_ready    (io_ready),
        .aes_ready   (aes_ready),
        .msg_de      (msg_de),
        .aes_reset_n (aes_reset_n),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Presents one word for a single clock and returns on the following negedge.
    task automatic applyStimulus(input logic [31:0] word);
        in_valid = 1'b1;
        in_data  = word;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int k;
        int n;
        logic seenValid;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        aes_ready = 1'b0;
        msg_de    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        checkOutput("rst_in_ready",    128'(in_ready),    128'd1);
        checkOutput("rst_io_ready",    128'(io_ready),    128'd0);
        checkOutput("rst_out_valid",   128'(out_valid),   128'd0);
        checkOutput("rst_out_last",    128'(out_last),    128'd0);
        checkOutput("rst_out_data",    128'(out_data),    128'd0);
        checkOutput("rst_key",         key,               128'd0);
        checkOutput("rst_msg_en",      msg_en,            128'd0);
        checkOutput("rst_timeout_err", 128'(timeout_err), 128'd0);
        checkOutput("rst_aes_reset_n", 128'(aes_reset_n), 128'd0);

        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("run_aes_reset_n", 128'(aes_reset_n), 128'd1);

        // Completion pulse while loading must be ignored
        aes_ready = 1'b1;
        msg_de    = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        @(negedge clk);
        aes_ready = 1'b0;
        msg_de    = '0;
        checkOutput("stray_ready_out_valid", 128'(out_valid), 128'd0);
        checkOutput("stray_ready_in_ready",  128'(in_ready),  128'd1);

        // Two partial key words, then reset discards them
        applyStimulus(32'hdeadbeef);
        applyStimulus(32'hcafef00d);
        in_valid = 1'b0;
        checkOutput("partial_key", key, 128'hdeadbeef_cafef00d_00000000_00000000);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("reset_low_aes_reset_n", 128'(aes_reset_n), 128'd0);
        checkOutput("reset_low_key",         key,               128'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            if (i == 7) checkOutput("pre_last_io_ready", 128'(io_ready), 128'd0);
            applyStimulus(loadWords[i]);
        end
        in_data = 32'h12345678;
        checkOutput("load_io_ready", 128'(io_ready), 128'd1);
        checkOutput("load_in_ready", 128'(in_ready), 128'd0);
        checkOutput("load_key",      key,    128'h000102030405060708090a0b0c0d0e0f);
        checkOutput("load_msg_en",   msg_en, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);

        for (int i = 1; i < AES_DELAY; i++) @(negedge clk);
        checkOutput("wait_io_ready",    128'(io_ready),    128'd1);
        checkOutput("wait_key_stable",  key,    128'h000102030405060708090a0b0c0d0e0f);
        checkOutput("wait_msg_stable",  msg_en, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        checkOutput("wait_timeout_err", 128'(timeout_err), 128'd0);
        checkOutput("wait_out_valid",   128'(out_valid),   128'd0);
        aes_ready = 1'b1;
        msg_de    = 128'h00112233445566778899aabbccddeeff;
        @(negedge clk);
        aes_ready = 1'b0;
        msg_de    = '0;
        in_valid  = 1'b0;
        checkOutput("unload_io_ready", 128'(io_ready), 128'd0);

        // Unload with out_ready alternating 1,0,1,0...
        k = 0;
        for (int c = 0; c < 16 && k < 4; c++) begin
            out_ready = (c % 2 == 0);
            checkOutput("unload_out_valid", 128'(out_valid), 128'd1);
            checkOutput("unload_out_data",  128'(out_data),  128'(plainWords[k]));
            checkOutput("unload_out_last",  128'(out_last),  128'(k == 3));
            @(posedge clk);
            @(negedge clk);
            if (out_ready) k++;
        end
        out_ready = 1'b0;
        checkOutput("unload_transfers",        128'(k),           128'd4);
        checkOutput("restart_aes_reset_n",     128'(aes_reset_n), 128'd0);
        checkOutput("restart_out_valid",       128'(out_valid),   128'd0);
        checkOutput("restart_in_ready",        128'(in_ready),    128'd0);
        @(negedge clk);
        checkOutput("after_restart_aes_reset_n", 128'(aes_reset_n), 128'd1);
        checkOutput("after_restart_in_ready",    128'(in_ready),    128'd1);

        // Second block: the controller never answers
        for (int i = 0; i < 8; i++) applyStimulus(loadWords[7 - i]);
        in_valid = 1'b0;
        checkOutput("second_msg_en", msg_en, 128'h0c0d0e0f08090a0b0405060700010203);

`ifdef AES_BRIDGE_TIMEOUT_EN
        n = 0;
        seenValid = 1'b0;
        while (io_ready && n < 100) begin
            if (out_valid) seenValid = 1'b1;
            n++;
            @(negedge clk);
        end
        checkOutput("wdog_wait_cycles",  128'(n),           128'd16);
        checkOutput("wdog_timeout_err",  128'(timeout_err), 128'd1);
        checkOutput("wdog_aes_reset_n",  128'(aes_reset_n), 128'd0);
        checkOutput("wdog_out_valid",    128'(out_valid | seenValid), 128'd0);
        @(negedge clk);
        checkOutput("wdog_in_ready",     128'(in_ready),    128'd1);
        checkOutput("wdog_aes_reset_hi", 128'(aes_reset_n), 128'd1);
        checkOutput("wdog_err_sticky",   128'(timeout_err), 128'd1);
`else
        n = 0;
        seenValid = 1'b0;
        repeat (40) begin
            if (out_valid) seenValid = 1'b1;
            n++;
            @(negedge clk);
        end
        checkOutput("nowdog_io_ready",    128'(io_ready),    128'd1);
        checkOutput("nowdog_timeout_err", 128'(timeout_err), 128'd0);
        checkOutput("nowdog_out_valid",   128'(out_valid | seenValid), 128'd0);
`endif

        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("final_key",         key,               128'd0);
        checkOutput("final_msg_en",      msg_en,            128'd0);
        checkOutput("final_timeout_err", 128'(timeout_err), 128'd0);
        checkOutput("final_in_ready",    128'(in_ready),    128'd1);
        checkOutput("final_io_ready",    128'(io_ready),    128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/aes_io_bridge.md
AES_IO_BRIDGE -- requirements
Module: aes_io_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16'd1024, meaning WAIT_AES cycles before abort (used only with AES_BRIDGE_TIMEOUT_EN).
REQ-002 SHALL have ports, one per line:
  clk  input  1  the one clock; all logic on posedge.
  reset_n  input  1  synchronous, active-low reset.
  in_valid  input  1  upstream word valid.
  in_ready  output  1  bridge accepts a word.
  in_data  input  32  key/ciphertext word.
  key  output  128  assembled key, to controller.
  msg_en  output  128  assembled ciphertext, to controller.
  io_ready  output  1  level request to controller to decrypt.
  aes_ready  input  1  controller decryption complete (level).
  msg_de  input  128  decrypted block from controller.
  aes_reset_n  output  1  active-low restart to controller.
  out_valid  output  1  plaintext word valid.
  out_ready  input  1  downstream accepts word.
  out_data  output  32  plaintext word.
  out_last  output  1  marks 4th plaintext word.
  timeout_err  output  1  sticky watchdog flag.

Function
REQ-003 SHALL implement states LOAD_KEY, LOAD_MSG, WAIT_AES, UNLOAD, RESTART.
REQ-004 Transfer SHALL occur on a posedge with in_valid&&in_ready (input) or out_valid&&out_ready (output); in_ready=1 only in LOAD_KEY/LOAD_MSG; out_valid=1 only in UNLOAD.
REQ-005 Word order SHALL be MSW first: word index 0 -> bits [127:96], index 3 -> [31:0]; 2-bit index wraps 3->0.
REQ-006 LOAD_KEY: 4 transfers fill key, then LOAD_MSG; LOAD_MSG: 4 transfers fill msg_en, then WAIT_AES on the cycle after the 4th transfer.
REQ-007 io_ready SHALL be 1 exactly while in WAIT_AES; key/msg_en SHALL be stable throughout WAIT_AES.
REQ-008 In WAIT_AES, aes_ready=1 SHALL capture msg_de into a result register and move to UNLOAD next cycle; aes_ready outside WAIT_AES SHALL be ignored.
REQ-009 UNLOAD: out_data = result word at index, out_last=1 at index 3; out_data stable while out_valid&&!out_ready; after last transfer -> RESTART.
REQ-010 RESTART SHALL last exactly one cycle, drive aes_reset_n=0, then LOAD_KEY; aes_reset_n = reset_n AND NOT(state==RESTART), so controller resets with the bridge.
REQ-011 Simultaneous in_valid with state change: only words accepted while in_ready=1 count; no word lost or duplicated across LOAD_KEY->LOAD_MSG.

Reset
REQ-012 reset_n=0 at posedge SHALL force LOAD_KEY, index 0, key/msg_en/result 0, io_ready 0, out_valid 0, out_last 0, out_data 0, timeout_err 0, watchdog counter 0.
REQ-013 Reset mid-operation SHALL discard partial words and any pending result; aes_reset_n SHALL be 0 while reset_n=0.

Configuration
REQ-014 With AES_BRIDGE_TIMEOUT_EN defined: 16-bit counter clears on WAIT_AES entry, increments each WAIT_AES cycle; reaching TIMEOUT_CYCLES without aes_ready SHALL set timeout_err (sticky until reset_n) and go to RESTART, skipping UNLOAD; aes_ready on the same cycle wins.
REQ-015 Without AES_BRIDGE_TIMEOUT_EN: no counter, timeout_err tied 0, WAIT_AES waits indefinitely.

Structure
REQ-016 Package aes_bridge_pkg SHALL hold the state enum, WORD_W=32, WORDS_PER_BLOCK=4, BLOCK_W=128.
REQ-017 Sub-module aes_word_reg (128-bit register, 32-bit indexed write, indexed read, clear) SHALL be instantiated for key, msg_en and result.

Verification
REQ-018 Load key 000102030405060708090a0b0c0d0e0f and ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a back-to-back -> io_ready rises cycle after 8th transfer, key/msg_en match.
REQ-019 Model controller returns msg_de 00112233445566778899aabbccddeeff after 20 cycles -> out words 00112233,44556677,8899aabb,ccddeeff, out_last on 4th, then one-cycle aes_reset_n=0.
REQ-020 out_ready toggled 1010... during UNLOAD -> each word held stable while stalled, exactly 4 transfers, no duplicates.
REQ-021 reset_n low after 2 key words, then full 8-word load -> key contains only post-reset words.
REQ-022 With AES_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=16, aes_ready never asserted -> timeout_err=1 after 16 WAIT_AES cycles, no out_valid, aes_reset_n pulse, in_ready=1 next cycle.
